// File: rtl/adxl_spi_pkg.sv
// ----------------------------------------------------------------------------
// adxl_spi_pkg
// Shared definitions for the ADXL345-style SPI responder: register addresses,
// register reset values, bit positions inside the control registers and the
// transfer state encoding.
// Optional build macro used by the top level: ADXL_SPI_RESPONDER_4WIRE_EN.
// ----------------------------------------------------------------------------
package adxl_spi_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] RST_BW_RATE     = 8'h0A;
    localparam logic [7:0] RST_POWER_CTL   = 8'h00;
    localparam logic [7:0] RST_INT_ENABLE  = 8'h00;
    localparam logic [7:0] RST_DATA_FORMAT = 8'h00;
    localparam logic [7:0] RST_INT_SOURCE  = 8'h00;

    localparam int MEASURE    = 3;  // POWER_CTL
    localparam int DATA_READY = 7;  // INT_SOURCE / INT_ENABLE
    localparam int INT_INVERT = 5;  // DATA_FORMAT
    localparam int SPI        = 6;  // DATA_FORMAT (1 = 3-wire)

    typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_e;

    // True for the six axis data byte addresses.
    function automatic logic is_data_addr(input logic [5:0] a);
        return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
    endfunction

endpackage

// File: rtl/adxl_spi_responder_edge_sync.sv
// ----------------------------------------------------------------------------
// spi_edge_sync
// Multi-flop synchroniser for an asynchronous pad signal followed by a
// rising/falling edge detector on the synchronised value.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (chain resets to RESET_VAL)
//   d_i     asynchronous input
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//   fall_o  one-cycle pulse on a synchronised 1->0 transition
// ----------------------------------------------------------------------------
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/adxl_spi_responder.sv
// ----------------------------------------------------------------------------
// adxl_spi_responder
// Emulates an ADXL345-style accelerometer on a 3-wire SPI link (mode 3) so
// the accelerometer driver can run without the real sensor.
// Ports:
//   clk_clk        system clock (>= 8x SCLK)
//   reset_reset_n  asynchronous active-low reset
//   spi_sclk       SPI clock from master (idles high)
//   spi_cs_n       chip select, active low
//   spi_sdat_i     SDIO input from the pad
//   spi_sdat_o     SDIO output data
//   spi_sdat_oe    SDIO output enable (1 = responder drives the pad)
//   spi_sdo        4-wire read data (only with ADXL_SPI_RESPONDER_4WIRE_EN)
//   int_o          G_SENSOR_INT, active high unless INT_INVERT is set
//   sample_x/y/z   two's-complement axis samples
//   sample_valid   single-cycle strobe qualifying the samples
// Build macro: ADXL_SPI_RESPONDER_4WIRE_EN adds spi_sdo and lets DATA_FORMAT
// bit SPI choose between 4-wire (0) and 3-wire (1) read data routing.
// ----------------------------------------------------------------------------
module adxl_spi_responder
    import adxl_spi_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_sdat_i,
    output logic        spi_sdat_o,
    output logic        spi_sdat_oe,
`ifdef ADXL_SPI_RESPONDER_4WIRE_EN
    output logic        spi_sdo,
`endif
    output logic        int_o,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk_i(clk_clk), .rst_ni(reset_reset_n), .d_i(spi_sclk),
        .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i(clk_clk), .rst_ni(reset_reset_n), .d_i(spi_cs_n),
        .rise_o(cs_rise), .fall_o(cs_fall)
    );

    // Same depth as the SCLK chain so the data bit lines up with its edge.
    logic [SYNC_STAGES-1:0] sdat_sync_q;
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) sdat_sync_q <= '0;
        else                sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], spi_sdat_i};
    end

    state_e      state_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [6:0]  tx_q;
    logic [5:0]  addr_q;
    logic        mb_q;
    logic        dr_read_q;   // a full data byte was returned this transaction
    logic        sdat_o_q, oe_q, int_q;
    logic [7:0]  bw_rate_q, power_ctl_q, int_enable_q, data_format_q, int_source_q;
    logic [15:0] live_x_q, live_y_q, live_z_q;
    logic [15:0] shd_x_q, shd_y_q, shd_z_q;

    logic [7:0]  rx_byte;
    logic [5:0]  next_addr;
    logic [7:0]  rd_data;
    logic        int_d;

    assign rx_byte   = {shift_q, sdat_sync_q[SYNC_STAGES-1]};
    assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;

    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            ADDR_DEVID:       rd_data = DEVID;
            ADDR_BW_RATE:     rd_data = bw_rate_q;
            ADDR_POWER_CTL:   rd_data = power_ctl_q;
            ADDR_INT_ENABLE:  rd_data = int_enable_q;
            ADDR_INT_SOURCE:  rd_data = int_source_q;
            ADDR_DATA_FORMAT: rd_data = data_format_q;
            ADDR_DATAX0:      rd_data = shd_x_q[7:0];
            ADDR_DATAX1:      rd_data = shd_x_q[15:8];
            ADDR_DATAY0:      rd_data = shd_y_q[7:0];
            ADDR_DATAY1:      rd_data = shd_y_q[15:8];
            ADDR_DATAZ0:      rd_data = shd_z_q[7:0];
            ADDR_DATAZ1:      rd_data = shd_z_q[15:8];
            default:          rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_q          <= '0;
            addr_q        <= '0;
            mb_q          <= 1'b0;
            dr_read_q     <= 1'b0;
            sdat_o_q      <= 1'b0;
            oe_q          <= 1'b0;
            bw_rate_q     <= RST_BW_RATE;
            power_ctl_q   <= RST_POWER_CTL;
            int_enable_q  <= RST_INT_ENABLE;
            data_format_q <= RST_DATA_FORMAT;
            int_source_q  <= RST_INT_SOURCE;
            live_x_q      <= '0;
            live_y_q      <= '0;
            live_z_q      <= '0;
            shd_x_q       <= '0;
            shd_y_q       <= '0;
            shd_z_q       <= '0;
        end else begin
            if (cs_fall) begin
                state_q   <= CMD;
                bit_cnt_q <= '0;
                dr_read_q <= 1'b0;
                oe_q      <= 1'b0;
                // Snapshot so a multibyte read sees one coherent sample.
                shd_x_q   <= live_x_q;
                shd_y_q   <= live_y_q;
                shd_z_q   <= live_z_q;
            end else if (cs_rise) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                oe_q      <= 1'b0;
                sdat_o_q  <= 1'b0;
                if (state_q == RDATA && dr_read_q)
                    int_source_q[DATA_READY] <= 1'b0;
            end else begin
                case (state_q)
                    CMD: begin
                        if (sclk_rise) begin
                            shift_q   <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                mb_q    <= rx_byte[6];
                                addr_q  <= rx_byte[5:0];
                                state_q <= rx_byte[7] ? RDATA : WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        // The first falling edge of each byte (count still 0)
                        // loads the byte for the current address.
                        if (sclk_fall) begin
                            oe_q <= 1'b1;
                            if (bit_cnt_q == 3'd0) begin
                                sdat_o_q <= rd_data[7];
                                tx_q     <= rd_data[6:0];
                            end else begin
                                sdat_o_q <= tx_q[6];
                                tx_q     <= {tx_q[5:0], 1'b0};
                            end
                        end
                        if (sclk_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                addr_q <= next_addr;
                                if (is_data_addr(addr_q)) dr_read_q <= 1'b1;
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            shift_q   <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                addr_q <= next_addr;
                                case (addr_q)
                                    ADDR_BW_RATE:     bw_rate_q     <= rx_byte;
                                    ADDR_POWER_CTL:   power_ctl_q   <= rx_byte;
                                    ADDR_INT_ENABLE:  int_enable_q  <= rx_byte;
                                    ADDR_DATA_FORMAT: data_format_q <= rx_byte;
                                    default: ;
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // Placed last so a new sample overrides a same-cycle clear.
            if (sample_valid && power_ctl_q[MEASURE]) begin
                live_x_q <= sample_x;
                live_y_q <= sample_y;
                live_z_q <= sample_z;
                int_source_q[DATA_READY] <= 1'b1;
            end
        end
    end

    assign int_d = (|(int_source_q & int_enable_q)) ^ data_format_q[INT_INVERT];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) int_q <= 1'b0;
        else                int_q <= int_d;
    end

    assign int_o      = int_q;
    assign spi_sdat_o = sdat_o_q;
`ifdef ADXL_SPI_RESPONDER_4WIRE_EN
    assign spi_sdo     = sdat_o_q;
    assign spi_sdat_oe = oe_q & data_format_q[SPI];
`else
    assign spi_sdat_oe = oe_q;
`endif

endmodule

// File: tb/tb_adxl_spi_responder.sv
// ----------------------------------------------------------------------------
// tb_adxl_spi_responder
// Directed bench for adxl_spi_responder: a mode-3 SPI master built from
// tasks drives register reads/writes, multibyte and wrap reads, an aborted
// write and a reset in the middle of a read. Expected values are fixed
// constants taken from the register map.
// ----------------------------------------------------------------------------
module tb_adxl_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b1;
    logic        cs_n = 1'b1;
    logic        sdi = 1'b0;
    logic        sdo, oe, intr;
    logic [15:0] sx = '0, sy = '0, sz = '0;
    logic        sv = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic        oe_acc;
    logic [7:0]  d, b;
    logic [7:0]  rb [6];
    logic [7:0]  exp6 [6];

    always #5 clk = ~clk;

    adxl_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_sdat_i(sdi),
        .spi_sdat_o(sdo), .spi_sdat_oe(oe), .int_o(intr),
        .sample_x(sx), .sample_y(sy), .sample_z(sz), .sample_valid(sv)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Shifts n bits MSB first; responder output is sampled just before each rise.
    task automatic xfer(input logic [7:0] v, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            sdi  = v[7-i];
            #80;
            rx[7-i] = sdo;
            oe_acc  = oe_acc & oe;
            sclk = 1'b1;
            #80;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_end();
        #80;
        cs_n = 1'b1;
        #200;
    endtask

    task automatic write_reg(input logic [5:0] a, input logic [7:0] v);
        logic [7:0] dummy;
        cs_begin();
        xfer({2'b00, a}, 8, dummy);
        xfer(v, 8, dummy);
        cs_end();
    endtask

    task automatic read1(input logic [7:0] cmd, output logic [7:0] r);
        logic [7:0] dummy;
        cs_begin();
        xfer(cmd, 8, dummy);
        oe_acc = 1'b1;
        xfer(8'h00, 8, r);
        cs_end();
    endtask

    task automatic pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sx = x; sy = y; sz = z; sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        exp6[0] = 8'h34; exp6[1] = 8'h12; exp6[2] = 8'hFE;
        exp6[3] = 8'hFF; exp6[4] = 8'h00; exp6[5] = 8'h01;

        // Reset state
        #33;
        chk("rst_oe", {15'd0, oe}, 16'd0);
        chk("rst_sdo", {15'd0, sdo}, 16'd0);
        chk("rst_int", {15'd0, intr}, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        #100;

        // DEVID read with output-enable timing
        cs_begin();
        xfer(8'h80, 8, d);
        chk("cmd_phase_oe", {15'd0, oe}, 16'd0);
        oe_acc = 1'b1;
        xfer(8'h00, 8, b);
        chk("devid", {8'd0, b}, 16'h00E5);
        chk("devid_oe_held", {15'd0, oe_acc}, 16'd1);
        #80;
        chk("oe_before_cs_high", {15'd0, oe}, 16'd1);
        @(negedge clk) cs_n = 1'b1;
        wait_clk(3);
        chk("oe_release_3cyc", {15'd0, oe}, 16'd0);
        #200;

        read1(8'hAC, b); chk("bw_rate_rst", {8'd0, b}, 16'h000A);

        // Write / read-back, and write to a read-only address
        write_reg(6'h2D, 8'h08);
        read1(8'hAD, b); chk("power_ctl_rb", {8'd0, b}, 16'h0008);
        write_reg(6'h00, 8'h55);
        read1(8'h80, b); chk("devid_ro", {8'd0, b}, 16'h00E5);

        // Sample capture and interrupt
        write_reg(6'h2E, 8'h80);
        wait_clk(4);
        chk("int_no_data", {15'd0, intr}, 16'd0);
        pulse(16'h1234, 16'hFFFE, 16'h0100);
        wait_clk(4);
        chk("int_data_ready", {15'd0, intr}, 16'd1);
        read1(8'hB0, b); chk("int_source", {8'd0, b}, 16'h0080);
        chk("int_after_src_read", {15'd0, intr}, 16'd1);

        // Coherent 6-byte read with a sample arriving mid-transfer
        cs_begin();
        xfer(8'hF2, 8, d);
        oe_acc = 1'b1;
        for (int k = 0; k < 2; k++) xfer(8'h00, 8, rb[k]);
        pulse(16'h1234, 16'hBEEF, 16'hCAFE);
        for (int k = 2; k < 6; k++) xfer(8'h00, 8, rb[k]);
        for (int k = 0; k < 6; k++) chk($sformatf("mb_byte%0d", k), {8'd0, rb[k]}, {8'd0, exp6[k]});
        chk("mb_oe_held", {15'd0, oe_acc}, 16'd1);
        // Strobe overlaps the cycle that handles CS_N rising.
        #80;
        @(negedge clk) cs_n = 1'b1;
        @(posedge clk);
        @(negedge clk) sv = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) sv = 1'b0;
        wait_clk(4);
        chk("int_set_wins", {15'd0, intr}, 16'd1);
        #200;

        // Address wrap with MB=1, then repeat with MB=0
        cs_begin();
        xfer(8'hFF, 8, d);
        xfer(8'h00, 8, rb[0]);
        xfer(8'h00, 8, rb[1]);
        cs_end();
        chk("wrap_3f", {8'd0, rb[0]}, 16'h0000);
        chk("wrap_00", {8'd0, rb[1]}, 16'h00E5);
        chk("int_after_nondata", {15'd0, intr}, 16'd1);

        cs_begin();
        xfer(8'hB2, 8, d);
        xfer(8'h00, 8, rb[0]);
        xfer(8'h00, 8, rb[1]);
        cs_end();
        chk("nomb_0", {8'd0, rb[0]}, 16'h0034);
        chk("nomb_1", {8'd0, rb[1]}, 16'h0034);
        chk("int_cleared", {15'd0, intr}, 16'd0);
        read1(8'hB4, b); chk("y0_new_sample", {8'd0, b}, 16'h00EF);

        // Aborted write after 4 data bits
        cs_begin();
        xfer(8'h2E, 8, d);
        xfer(8'h00, 4, d);
        cs_end();
        read1(8'hAE, b); chk("abort_int_enable", {8'd0, b}, 16'h0080);
        read1(8'h80, b); chk("after_abort_devid", {8'd0, b}, 16'h00E5);

        // Measure off: strobe ignored
        write_reg(6'h2D, 8'h00);
        pulse(16'h1111, 16'h2222, 16'h3333);
        wait_clk(4);
        chk("measure_off_int", {15'd0, intr}, 16'd0);
        read1(8'hB0, b); chk("measure_off_src", {8'd0, b}, 16'h0000);

        // INT_INVERT
        write_reg(6'h31, 8'h20);
        wait_clk(4);
        chk("int_inverted", {15'd0, intr}, 16'd1);
        read1(8'hB1, b); chk("data_format_rb", {8'd0, b}, 16'h0020);

        // Reset in the middle of a read
        cs_begin();
        xfer(8'h80, 8, d);
        oe_acc = 1'b1;
        xfer(8'h00, 3, b);
        chk("midread_oe", {15'd0, oe}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", {15'd0, oe}, 16'd0);
        chk("rst_mid_int", {15'd0, intr}, 16'd0);
        chk("rst_mid_sdo", {15'd0, sdo}, 16'd0);
        cs_n = 1'b1;
        sclk = 1'b1;
        #50;
        @(negedge clk) rst_n = 1'b1;
        #200;
        read1(8'hAC, b); chk("rst_bw_rate", {8'd0, b}, 16'h000A);
        read1(8'hAD, b); chk("rst_power_ctl", {8'd0, b}, 16'h0000);
        read1(8'hAE, b); chk("rst_int_enable", {8'd0, b}, 16'h0000);
        read1(8'hB1, b); chk("rst_data_format", {8'd0, b}, 16'h0000);
        read1(8'hB0, b); chk("rst_int_source", {8'd0, b}, 16'h0000);
        read1(8'hB2, b); chk("rst_shadow_x0", {8'd0, b}, 16'h0000);
        chk("rst_int_final", {15'd0, intr}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adxl_spi_responder.md
Name: adxl_spi_responder

Overview:
- Synthesizable 3-wire SPI responder emulating the G-sensor at the far end of the accelerometer SPI link (SDAT/SCLK/CS_N/INT).
- Lets the NIOS accelerometer path run on a board or bench without the real sensor. x/y/z samples come from a local source (switch-driven pattern generator or testbench).
- Implements the ADXL345-style register protocol subset the driver uses, and drives G_SENSOR_INT.

Parameters:
- DEVID, 8'hE5, value returned at address 0x00
- SYNC_STAGES, 2, synchroniser depth for spi_sclk, spi_cs_n, spi_sdat_i

Ports:
- clk_clk  in  1  system clock; must be at least 8x SCLK frequency
- reset_reset_n  in  1  asynchronous active-low reset
- spi_sclk  in  1  SPI clock from master, mode 3 (CPOL=1, CPHA=1)
- spi_cs_n  in  1  chip select, active low
- spi_sdat_i  in  1  SDIO input from the top-level tristate pad
- spi_sdat_o  out  1  SDIO output data
- spi_sdat_oe  out  1  SDIO output enable (1 = responder drives pad)
- int_o  out  1  G_SENSOR_INT, active high
- sample_x, sample_y, sample_z  in  16 each  two's-complement axis data
- sample_valid  in  1  single-cycle strobe; sample inputs valid

Behaviour:
- Reset values:
  - spi_sdat_o=0, spi_sdat_oe=0, int_o=0
  - state IDLE; live and shadow data registers 0
  - BW_RATE(0x2C)=0x0A, POWER_CTL(0x2D)=0x00, INT_ENABLE(0x2E)=0x00, DATA_FORMAT(0x31)=0x00, INT_SOURCE(0x30)=0x00
- Synchronisation: SCLK, CS_N and SDAT pass through SYNC_STAGES flops. Edge detect on the synchronised SCLK. Responder reactions occur 2-3 clk_clk cycles after the pad edge.
- Framing and addressing:
  - Bit order MSB first. Sample on SCLK rising edge; update spi_sdat_o on SCLK falling edge.
  - Command byte: bit7 R/W (1 = read), bit6 MB (multibyte), bits5:0 address.
- FSM:
  - IDLE -> CMD on CS_N falling edge. Bit counter cleared. Live x/y/z copied to shadow registers (coherent multibyte read).
  - CMD -> RDATA or WDATA after the 8th rising edge.
  - RDATA: first read byte is loaded at the next falling edge. spi_sdat_oe goes to 1 at that falling edge and stays 1 until CS_N rises.
  - WDATA: byte is committed on its 8th rising edge. Only 0x2C, 0x2D, 0x2E, 0x31 are writable; writes elsewhere are ignored.
  - Any state -> IDLE on CS_N rising edge. Partial bytes are discarded, spi_sdat_oe=0 within 3 cycles, no register commit.
- Address sequencing per byte: MB=1 increments the address, wrapping 0x3F -> 0x00. MB=0 repeats the same address.
- Read map:
  - 0x00 = DEVID
  - 0x32..0x37 = shadow X0, X1, Y0, Y1, Z0, Z1 (low byte first)
  - 0x30 = INT_SOURCE
  - writable registers read back their value; all others read 0x00
- Sample capture: sample_valid with POWER_CTL bit3 (measure) set loads the live registers and sets INT_SOURCE bit7 (DATA_READY). With measure=0 the strobe is ignored.
- DATA_READY clear: cleared at CS_N rising edge ending a read transaction that returned at least one full byte from 0x32..0x37. If sample_valid occurs in the same cycle, set wins.
- Interrupt: int_o = |(INT_SOURCE & INT_ENABLE), registered (1-cycle latency). DATA_FORMAT bit5 (INT_INVERT) inverts int_o.
- Reset mid-transfer: immediate return to reset values; the master sees a released bus.

Optional Feature:
- Macro: ADXL_SPI_RESPONDER_4WIRE_EN.
- Defined:
  - Adds output port spi_sdo (1 bit).
  - When DATA_FORMAT bit6 (SPI) = 0, read data goes on spi_sdo and spi_sdat_oe stays 0 (4-wire).
  - When bit6 = 1, behaviour is 3-wire as above.
- Undefined: no spi_sdo port; always 3-wire; DATA_FORMAT bit6 is stored but has no effect.

Decomposition:
- Package adxl_spi_pkg:
  - register address constants (ADDR_DEVID, ADDR_BW_RATE, ADDR_POWER_CTL, ADDR_INT_ENABLE, ADDR_INT_SOURCE, ADDR_DATA_FORMAT, ADDR_DATAX0..ADDR_DATAZ1)
  - reset-value constants
  - state enum typedef (IDLE, CMD, RDATA, WDATA)
  - bit-index constants (MEASURE=3, DATA_READY=7, INT_INVERT=5, SPI=6)
- One sub-module: spi_edge_sync. It holds the SYNC_STAGES synchroniser plus rise/fall detect, and is instantiated for SCLK and CS_N.

Test Plan:
- Read DEVID: CS low, command 0x80, 8 clocks -> 0xE5 on SDAT with oe=1 from the first falling edge after the command; oe=0 within 3 cycles of CS high.
- Write then read back: write 0x2D <- 0x08; read 0x2D -> 0x08. Write 0x00 <- 0x55; read 0x00 -> still 0xE5.
- Multibyte coherency:
  - Setup: measure on, INT_ENABLE=0x80. Sample x=0x1234, y=0xFFFE, z=0x0100 -> int_o=1.
  - Command 0xF2: during the 6-byte read, pulse a new sample -> bytes 34 12 FE FF 00 01.
  - After CS high, int_o=1 (set wins over clear).
- Wrap and MB=0: command 0xFF with 2 bytes -> reads 0x00 then 0xE5. Command 0xB2 with 2 bytes -> 0x34, 0x34.
- Abort: write 0x2E, drop CS after 4 data bits -> INT_ENABLE unchanged, state IDLE. Next full transaction behaves normally.
- Reset mid-read: assert reset_reset_n=0 during the RDATA phase -> oe=0 and int_o=0 immediately; all registers at reset values.
